seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It drives the shared 4-bit BCD input of the existing segmentdisplay decoder and one active-low anode per digit. Digits are shown one at a time, with a guard (all-off) interval between digits to suppress ghosting. A new display value is accepted through a load strobe and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be at least 2.
REFRESH_DIV, 1000, clock cycles each digit is lit (SHOW dwell); must be at least 1.
GUARD_CYC, 2, clock cycles with all anodes off before each digit; 0 disables the guard.
BLANK_LEAD, 1, 1 = suppress leading-zero digits; digit 0 is never suppressed.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
load  in  1  single-cycle strobe: capture value.
value  in  4*NUM_DIGITS  packed BCD; digit k = value[4k+3:4k]; digit 0 is least significant.
bcd  out  4  to decoder bcd input; the nibble for the digit currently shown.
an  out  NUM_DIGITS  active-low anode enables; at most one bit low.
blank  out  1  1 = segments must be off (guard interval, or a suppressed digit).
pending  out  1  a loaded value is waiting for the next frame boundary.
frame_done  out  1  one-cycle pulse at the end of the last digit's SHOW interval.

Behaviour:
- Reset (asynchronous assert, synchronous release) sets:
  - state=GUARD, idx=0, cnt=0, active=0, shadow=0.
  - pending=0, frame_done=0, an=all 1s, bcd=0, blank=1.
- All outputs are registers. Each output reflects the state entered on the same clock edge.
- State GUARD:
  - an=all 1s, blank=1, bcd holds its last value.
  - cnt counts 0 to GUARD_CYC-1, then the block enters SHOW with cnt=0.
  - If GUARD_CYC=0, GUARD is skipped: SHOW exits directly into the next SHOW. After reset the first SHOW starts on the first edge.
- State SHOW:
  - an[idx]=0, all other anode bits 1.
  - bcd = active digit idx.
  - blank=1 when the digit is suppressed, else 0. When blank=1 the anode still follows idx.
  - cnt counts 0 to REFRESH_DIV-1. On reaching the end, the block enters GUARD and idx advances.
- idx advance: idx increments by 1 and wraps from NUM_DIGITS-1 to 0.
- Frame boundary:
  - Defined as the SHOW-exit edge with idx=NUM_DIGITS-1.
  - frame_done=1 for exactly that one cycle.
  - If pending=1: active is loaded from shadow and pending is cleared.
- Load handling:
  - load=1 captures value into shadow and sets pending=1.
  - A load while pending=1 overwrites shadow; the last load wins.
  - A load on a frame-boundary edge writes value directly into active and leaves pending=0. The older shadow is discarded.
- Leading-zero suppression (BLANK_LEAD=1):
  - Digit k (k>0) is suppressed when active digits k through NUM_DIGITS-1 are all 0.
  - The suppression mask is computed from active, so it changes only at a frame boundary.
- Frame length = NUM_DIGITS*(REFRESH_DIV+GUARD_CYC) cycles.
- Nibbles above 9 are passed through unchanged; the decoder handles them.
- Reset mid-frame: all state returns to reset values immediately, and any pending value is lost.

Decomposition:
- Shared package (seg_pkg): state encoding (GUARD, SHOW), and the anode active level / segment-off constant, shared with the decoder and board top.
- Natural sub-module: seg_lz_mask, a combinational block mapping active to an NUM_DIGITS-bit suppress mask.
- The segmentdisplay decoder is instantiated at top level, not inside this block.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYC=1, so one frame is 20 cycles.
1. Reset, no load -> an=1111, blank=1 during reset. After release: only digit 0 unblanked, with bcd=0, an=1110. Digits 1-3 blank=1.
2. load value=16'h1234 mid-frame -> pending=1, display unchanged until frame_done. Next frame: bcd sequence 4,3,2,1 with an 1110,1101,1011,0111; each digit lit 4 cycles, separated by 1 cycle of an=1111. pending=0.
3. load 16'h0050 at a frame boundary -> takes effect with no pending. Shows 0 on digit 0 and 5 on digit 1; digits 2 and 3 blank=1. Repeat with BLANK_LEAD=0: digits 2 and 3 show bcd=0, blank=0.
4. load 16'h1111 then 16'h2222 within one frame -> next frame shows all 2s; frame_done is exactly one cycle, every 20 cycles.
5. Assert rst mid-SHOW of digit 2 -> outputs go to reset values without waiting for a clock edge. Scan restarts at digit 0 with active=0.
6. value=16'hFA98, GUARD_CYC=0 -> bcd 8,9,A,F passed through unchanged. No cycle has an=1111, and at most one anode is low every cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan path: scan state encoding and
// the electrical levels seen by the decoder and the board top.
package seg_pkg;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Common-anode display: anode enables are active low.
    localparam logic AN_ON  = 1'b0;
    localparam logic AN_OFF = 1'b1;

    // Level of the blank output that forces all segments off.
    localparam logic SEG_OFF = 1'b1;

    localparam logic [3:0] BCD_IDLE = 4'h0;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value-load and display-drive bundle between a value producer and seg_scan_ctrl.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [3:0]              bcd;
    logic [NUM_DIGITS-1:0]   an;
    logic                    blank;
    logic                    pending;
    logic                    frame_done;

    modport master (
        output load, value,
        input  bcd, an, blank, pending, frame_done
    );

    modport slave (
        input  load, value,
        output bcd, an, blank, pending, frame_done
    );
endinterface

// File: rtl/seg_lz_mask.sv
// Leading-zero suppress mask: digit k (k>0) is suppressed when digits
// k..NUM_DIGITS-1 are all zero. Digit 0 is always shown.
module seg_lz_mask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   suppress
);
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_mask
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = (digits[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display with
// guard intervals, frame-aligned value updates and leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GUARD_CYC   = 2,
    parameter int BLANK_LEAD  = 1
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int VW      = 4 * NUM_DIGITS;
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t           state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [VW-1:0]         active_reg, active_next;
    logic [VW-1:0]         shadow_reg, shadow_next;
    logic                  pending_reg, pending_next;
    logic                  frame_done_reg, frame_done_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic [3:0]            bcd_reg, bcd_next;
    logic                  blank_reg, blank_next;
    logic                  boundary;

    logic [NUM_DIGITS-1:0] suppress;
    logic [3:0]            digit_next [NUM_DIGITS];

    // Mask and digit select follow the value that will be active after this edge,
    // so a frame-boundary update is visible on the very first digit of the new frame.
    seg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
        .digits   (active_next),
        .suppress (suppress)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_next[gi] = active_next[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        boundary   = 1'b0;
        case (state_reg)
            ST_GUARD: begin
                if (GUARD_CYC == 0 || cnt_reg == GUARD_LAST) begin
                    state_next = ST_SHOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_reg == SHOW_LAST) begin
                    cnt_next   = '0;
                    boundary   = (idx_reg == IDX_LAST);
                    idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
                    state_next = (GUARD_CYC == 0) ? ST_SHOW : ST_GUARD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_GUARD;
        endcase
    end

    // A load coinciding with the boundary bypasses the shadow entirely.
    always_comb begin
        active_next  = active_reg;
        shadow_next  = shadow_reg;
        pending_next = pending_reg;
        if (boundary) begin
            if (bus.load) begin
                active_next = bus.value;
            end else if (pending_reg) begin
                active_next = shadow_reg;
            end
            pending_next = 1'b0;
        end else if (bus.load) begin
            shadow_next  = bus.value;
            pending_next = 1'b1;
        end
    end

    always_comb begin
        an_next         = {NUM_DIGITS{AN_OFF}};
        blank_next      = SEG_OFF;
        bcd_next        = bcd_reg;
        frame_done_next = boundary;
        if (state_next == ST_SHOW) begin
            an_next[idx_next] = AN_ON;
            bcd_next          = digit_next[idx_next];
            blank_next        = (BLANK_LEAD != 0) && suppress[idx_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_GUARD;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            active_reg     <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            an_reg         <= {NUM_DIGITS{AN_OFF}};
            bcd_reg        <= BCD_IDLE;
            blank_reg      <= SEG_OFF;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            active_reg     <= active_next;
            shadow_reg     <= shadow_next;
            pending_reg    <= pending_next;
            frame_done_reg <= frame_done_next;
            an_reg         <= an_next;
            bcd_reg        <= bcd_next;
            blank_reg      <= blank_next;
        end
    end

    assign bus.bcd        = bcd_reg;
    assign bus.an         = an_reg;
    assign bus.blank      = blank_reg;
    assign bus.pending    = pending_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: three configurations share one stimulus stream and are
// checked every cycle against a frame-timeline model plus literal scenario checks.
module tb_seg_scan_ctrl;
    localparam int N  = 4;
    localparam int R  = 4;
    localparam int NC = 3;

    function automatic int g_of(input int c);
        return (c == 2) ? 0 : 1;
    endfunction

    function automatic int bl_of(input int c);
        return (c == 1) ? 0 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) if_a ();
    seg_scan_ctrl_if #(.NUM_DIGITS(N)) if_b ();
    seg_scan_ctrl_if #(.NUM_DIGITS(N)) if_c ();

    assign if_a.load = load;
    assign if_a.value = value;
    assign if_b.load = load;
    assign if_b.value = value;
    assign if_c.load = load;
    assign if_c.value = value;

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYC(1), .BLANK_LEAD(1)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a));
    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYC(1), .BLANK_LEAD(0)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b));
    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYC(0), .BLANK_LEAD(1)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c));

    logic [3:0] got_an  [NC];
    logic [3:0] got_bcd [NC];
    logic       got_blank [NC];
    logic       got_pend  [NC];
    logic       got_fd    [NC];

    assign got_an[0] = if_a.an;   assign got_bcd[0] = if_a.bcd;   assign got_blank[0] = if_a.blank;
    assign got_an[1] = if_b.an;   assign got_bcd[1] = if_b.bcd;   assign got_blank[1] = if_b.blank;
    assign got_an[2] = if_c.an;   assign got_bcd[2] = if_c.bcd;   assign got_blank[2] = if_c.blank;
    assign got_pend[0] = if_a.pending; assign got_fd[0] = if_a.frame_done;
    assign got_pend[1] = if_b.pending; assign got_fd[1] = if_b.frame_done;
    assign got_pend[2] = if_c.pending; assign got_fd[2] = if_c.frame_done;

    task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", name, c, got, exp, $time);
        end
    endtask

    // Model: edges since reset give a position q on an endless timeline of
    // digit slots (GUARD cycles then R SHOW cycles each); reset state sits at q=G-1.
    int          m_e   [NC] = '{0, 0, 0};
    int          m_q   [NC] = '{0, 0, 0};
    logic        m_pend[NC] = '{1'b0, 1'b0, 1'b0};
    logic        m_bnd [NC] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] m_act [NC] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] m_sh  [NC] = '{16'h0, 16'h0, 16'h0};
    logic [3:0]  m_bcd [NC] = '{4'h0, 4'h0, 4'h0};

    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            int g, slot, q;
            g = g_of(c);
            slot = R + g;
            if (rst) begin
                m_e[c] = 0; m_q[c] = 0; m_pend[c] = 1'b0; m_bnd[c] = 1'b0;
                m_act[c] = 16'h0; m_sh[c] = 16'h0; m_bcd[c] = 4'h0;
            end else begin
                m_e[c] = m_e[c] + 1;
                q = g - 1 + m_e[c];
                m_q[c] = q;
                m_bnd[c] = (q > 0) && (q % (N * slot) == 0);
                if (m_bnd[c]) begin
                    if (load) m_act[c] = value;
                    else if (m_pend[c]) m_act[c] = m_sh[c];
                    m_pend[c] = 1'b0;
                end else if (load) begin
                    m_sh[c] = value;
                    m_pend[c] = 1'b1;
                end
                if ((q % slot) >= g) m_bcd[c] = 4'((m_act[c] >> (4 * ((q / slot) % N))) & 16'hF);
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            logic [3:0] e_an, one_hot, e_bcd;
            logic e_blank, e_pend, e_fd, show;
            int g, slot, dig;
            g = g_of(c);
            slot = R + g;
            if (rst || m_e[c] == 0) begin
                e_an = 4'hF; e_blank = 1'b1; e_bcd = 4'h0; e_pend = 1'b0; e_fd = 1'b0;
            end else begin
                dig = (m_q[c] / slot) % N;
                show = (m_q[c] % slot) >= g;
                one_hot = 4'b0001 << dig;
                e_an = show ? ~one_hot : 4'hF;
                e_blank = show ? ((bl_of(c) != 0) && dig > 0 && (m_act[c] >> (4 * dig)) == 16'h0) : 1'b1;
                e_bcd = m_bcd[c]; e_pend = m_pend[c]; e_fd = m_bnd[c];
            end
            check("an", c, 32'(got_an[c]), 32'(e_an));
            check("bcd", c, 32'(got_bcd[c]), 32'(e_bcd));
            check("blank", c, 32'(got_blank[c]), 32'(e_blank));
            check("pending", c, 32'(got_pend[c]), 32'(e_pend));
            check("frame_done", c, 32'(got_fd[c]), 32'(e_fd));
        end
    end

    task automatic wait_q(input int target);
        int n;
        n = 0;
        while (!(rst == 1'b0 && m_e[0] > 0 && m_q[0] == target) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_q_timeout", 0, 32'(n >= 400), 32'd0);
    endtask

    task automatic wait_fd(input int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!got_fd[c] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_fd_timeout", c, 32'(got_fd[c]), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v);
        #1;
        load = 1'b1;
        value = v;
        $display("[TB] load value=%h (timeline q=%0d)", v, m_q[0]);
        @(negedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic capture(input int c, input int ncyc, output logic [15:0] seq_bcd,
                           output logic [15:0] seq_an, output int guards, output int lit,
                           output int fds, output int bad);
        logic [3:0] prev_an;
        prev_an = 4'hF; seq_bcd = '0; seq_an = '0;
        guards = 0; lit = 0; fds = 0; bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk);
            if (got_an[c] == 4'hF) begin
                guards++;
            end else begin
                lit++;
                if (!$onehot(~got_an[c])) bad++;
                if (got_an[c] != prev_an) begin
                    seq_bcd = {seq_bcd[11:0], got_bcd[c]};
                    seq_an  = {seq_an[11:0], got_an[c]};
                end
            end
            if (got_fd[c]) fds++;
            prev_an = got_an[c];
        end
    endtask

    initial begin
        logic [15:0] sb, sa;
        int gd, lt, fd, bd;

        // Reset, no load
        repeat (3) @(negedge clk);
        check("rst_an", 0, 32'(if_a.an), 32'hF);
        check("rst_blank", 0, 32'(if_a.blank), 32'd1);
        #1 rst = 1'b0;
        wait_q(1);
        check("t1_an0", 0, 32'(if_a.an), 32'hE);
        check("t1_bcd0", 0, 32'(if_a.bcd), 32'h0);
        check("t1_blank0", 0, 32'(if_a.blank), 32'd0);
        wait_q(6);
        check("t1_an1", 0, 32'(if_a.an), 32'hD);
        check("t1_blank1", 0, 32'(if_a.blank), 32'd1);

        // Mid-frame load waits for the boundary
        wait_q(7);
        do_load(16'h1234);
        check("t2_pending", 0, 32'(if_a.pending), 32'd1);
        check("t2_bcd_unchanged", 0, 32'(if_a.bcd), 32'h0);
        wait_fd(0);
        capture(0, 20, sb, sa, gd, lt, fd, bd);
        check("t2_seq_bcd", 0, 32'(sb), 32'h4321);
        check("t2_seq_an", 0, 32'(sa), 32'hEDB7);
        check("t2_guards", 0, 32'(gd), 32'd4);
        check("t2_lit", 0, 32'(lt), 32'd16);
        check("t2_pending_clr", 0, 32'(if_a.pending), 32'd0);

        // Load on the boundary edge
        wait_q(39);
        do_load(16'h0050);
        check("t3_pending", 0, 32'(if_a.pending), 32'd0);
        check("t3_fd", 0, 32'(if_a.frame_done), 32'd1);
        wait_q(46);
        check("t3_bcd5", 0, 32'(if_a.bcd), 32'h5);
        check("t3_blank1", 0, 32'(if_a.blank), 32'd0);
        wait_q(51);
        check("t3_an2", 0, 32'(if_a.an), 32'hB);
        check("t3_lz_blank2", 0, 32'(if_a.blank), 32'd1);
        check("t3_nolz_blank2", 1, 32'(if_b.blank), 32'd0);
        check("t3_nolz_bcd2", 1, 32'(if_b.bcd), 32'h0);
        wait_q(56);
        check("t3_nolz_an3", 1, 32'(if_b.an), 32'h7);
        check("t3_nolz_blank3", 1, 32'(if_b.blank), 32'd0);

        // Last load wins
        wait_q(62);
        do_load(16'h1111);
        wait_q(66);
        do_load(16'h2222);
        check("t4_pending", 0, 32'(if_a.pending), 32'd1);
        wait_q(80);
        check("t4_fd", 0, 32'(if_a.frame_done), 32'd1);
        capture(0, 60, sb, sa, gd, lt, fd, bd);
        check("t4_seq_bcd", 0, 32'(sb), 32'h2222);
        check("t4_fd_count", 0, 32'(fd), 32'd3);
        check("t4_guards", 0, 32'(gd), 32'd12);

        // Asynchronous reset mid-SHOW of digit 2, with a value pending
        wait_q(150);
        do_load(16'h9999);
        wait_q(152);
        check("t5_an2", 0, 32'(if_a.an), 32'hB);
        check("t5_pending_pre", 0, 32'(if_a.pending), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_an_async", 0, 32'(if_a.an), 32'hF);
        check("t5_blank_async", 0, 32'(if_a.blank), 32'd1);
        check("t5_bcd_async", 0, 32'(if_a.bcd), 32'h0);
        check("t5_pending_async", 0, 32'(if_a.pending), 32'd0);
        check("t5_fd_async", 0, 32'(if_a.frame_done), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        wait_q(1);
        check("t5_restart_an", 0, 32'(if_a.an), 32'hE);
        check("t5_restart_bcd", 0, 32'(if_a.bcd), 32'h0);

        // Randomized loads, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            logic [15:0] v;
            @(negedge clk);
            #1;
            v = 16'($urandom);
            case ($urandom_range(3))
                1: v = v & 16'h00FF;
                2: v = v & 16'h000F;
                3: v = 16'h0;
                default: ;
            endcase
            value = v;
            load = ($urandom_range(7) == 0);
            if (load) $display("[TB] load value=%h (timeline q=%0d)", v, m_q[0]);
        end
        @(negedge clk);
        #1 load = 1'b0;

        // No guard, nibbles above 9 passed through
        @(negedge clk);
        do_load(16'hFA98);
        wait_fd(2);
        wait_fd(2);
        capture(2, 16, sb, sa, gd, lt, fd, bd);
        check("t6_seq_bcd", 2, 32'(sb), 32'h89AF);
        check("t6_seq_an", 2, 32'(sa), 32'hEDB7);
        check("t6_no_allon", 2, 32'(gd), 32'd0);
        check("t6_onehot", 2, 32'(bd), 32'd0);
        check("t6_fd_count", 2, 32'(fd), 32'd1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
